// File: rtl/graph_pkg.sv
// graph_pkg: shared walker FSM state, neighbour beat layout and tag width
package graph_pkg;
  localparam int TAG_W = 5;
  typedef enum logic [2:0] {IDLE, REQ_S, WAIT_S, REQ_E, WAIT_E, STREAM, FINISH} walker_state_t;
  typedef struct packed {
    logic             last;
    logic [TAG_W-1:0] tag;
    logic [31:0]      id;
  } nbr_beat_t;
endpackage

// File: rtl/csr_row_walker_fifo.sv
// csr_row_walker_fifo: registered-output FIFO (clk, rst, push/wdata in, pop in, rdata/empty/count out) with occupancy count, no bypass
module csr_row_walker_fifo #(
  parameter int DATA_WIDTH = 38,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic                         pop,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push_ok, pop_ok;
  assign pop_ok = pop && count != '0;
  assign push_ok = push && count != CW'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rp];
  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp == AW'(DEPTH-1) ? '0 : wp + 1'b1;
      if (pop_ok) rp <= rp == AW'(DEPTH-1) ? '0 : rp + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/csr_row_walker.sv
// csr_row_walker: CSR row walker (vertex/tag req in, rowidx + data read ports, tagged neighbour FIFO out, done/edge_count/error pulses); CSR_ROW_WALKER_BOUNDS_CHECK_EN enables end<start error
module csr_row_walker import graph_pkg::*; #(
  parameter int          DEPTH = 8,
  parameter logic [31:0] ROWIDX_BASE = 32'h0,
  parameter logic [31:0] DATA_BASE = 32'h0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [31:0]      vertex_in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             vertex_valid_in,
  output logic             vertex_ready_out,
  output logic [31:0]      rowidx_addr_out,
  output logic             rowidx_req_out,
  input  logic [31:0]      rowidx_in,
  input  logic             rowidx_valid_in,
  output logic [31:0]      data_addr_out,
  output logic             data_req_out,
  input  logic [31:0]      data_in,
  input  logic             data_valid_in,
  output logic [31:0]      nbr_out,
  output logic [TAG_W-1:0] nbr_tag_out,
  output logic             nbr_last_out,
  output logic             nbr_valid_out,
  input  logic             nbr_ready_in,
  output logic             done_out,
  output logic [31:0]      edge_count_out,
  output logic             error_out
);
  localparam int CW = $clog2(DEPTH+1);
  walker_state_t state, state_nxt;
  logic [31:0] v, start_r, end_r, idx, cnt;
  logic [TAG_W-1:0] tag;
  logic [CW-1:0] outstanding, fifo_count;
  logic issue, resp, bad, fifo_empty;
  nbr_beat_t beat_in, beat_out;
`ifdef CSR_ROW_WALKER_BOUNDS_CHECK_EN
  assign bad = rowidx_in < start_r;
`else
  assign bad = 1'b0;
`endif
  // FIFO slots plus in-flight reads never exceed DEPTH, so a response always has room
  assign issue = state == STREAM && idx != end_r &&
                 ({1'b0, fifo_count} + {1'b0, outstanding} < (CW+1)'(DEPTH));
  assign resp = data_valid_in && outstanding != '0;
  assign beat_in = '{last: idx == end_r && outstanding == CW'(1), tag: tag, id: data_in};
  assign data_req_out = issue;
  assign data_addr_out = issue ? DATA_BASE + idx : '0;
  assign nbr_valid_out = !fifo_empty;
  assign {nbr_last_out, nbr_tag_out, nbr_out} = nbr_valid_out ? beat_out : '0;
  csr_row_walker_fifo #(.DATA_WIDTH($bits(nbr_beat_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk_in),
    .rst(rst_in),
    .push(resp),
    .wdata(beat_in),
    .pop(nbr_valid_out && nbr_ready_in),
    .rdata(beat_out),
    .empty(fifo_empty),
    .count(fifo_count)
  );
  always_ff @(posedge clk_in)
    state <= rst_in ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    vertex_ready_out = 1'b0;
    rowidx_req_out = 1'b0;
    rowidx_addr_out = '0;
    done_out = 1'b0;
    edge_count_out = '0;
    error_out = 1'b0;
    case (state)
      IDLE: begin
        vertex_ready_out = 1'b1;
        state_nxt = vertex_valid_in ? REQ_S : IDLE;
      end
      REQ_S: begin
        rowidx_req_out = 1'b1;
        rowidx_addr_out = ROWIDX_BASE + v;
        state_nxt = WAIT_S;
      end
      WAIT_S: state_nxt = rowidx_valid_in ? REQ_E : WAIT_S;
      REQ_E: begin
        rowidx_req_out = 1'b1;
        rowidx_addr_out = ROWIDX_BASE + v + 32'd1;
        state_nxt = WAIT_E;
      end
      WAIT_E: begin
        error_out = rowidx_valid_in && bad;
        state_nxt = !rowidx_valid_in ? WAIT_E : (bad || rowidx_in == start_r) ? FINISH : STREAM;
      end
      STREAM: state_nxt = idx == end_r && outstanding == '0 ? FINISH : STREAM;
      FINISH: begin
        done_out = 1'b1;
        edge_count_out = cnt;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      v <= '0;
      tag <= '0;
      start_r <= '0;
      end_r <= '0;
      idx <= '0;
      cnt <= '0;
      outstanding <= '0;
    end else begin
      if (state == IDLE && vertex_valid_in) begin
        v <= vertex_in;
        tag <= tag_in;
      end
      if (state == WAIT_S && rowidx_valid_in) begin
        start_r <= rowidx_in;
        idx <= rowidx_in;
      end
      if (state == WAIT_E && rowidx_valid_in) begin
        end_r <= rowidx_in;
        cnt <= bad ? '0 : rowidx_in - start_r;
      end
      if (issue) idx <= idx + 32'd1;
      outstanding <= outstanding + CW'(issue) - CW'(resp);
    end
  end
endmodule

// File: tb/tb_csr_row_walker.sv
// tb_csr_row_walker: randomized self-checking bench for csr_row_walker against a row/edge-list reference model
module tb_csr_row_walker;
  localparam int DEPTH = 2;
  localparam logic [31:0] RB = 32'h100;
  localparam logic [31:0] DB = 32'h4000;
  logic clk = 0, rst_in = 1;
  logic [31:0] vertex_in = 0;
  logic [4:0] tag_in = 0;
  logic vertex_valid_in = 0, vertex_ready_out;
  logic [31:0] rowidx_addr_out, rowidx_in = 0, data_addr_out, data_in = 0, nbr_out, edge_count_out;
  logic rowidx_req_out, rowidx_valid_in = 0, data_req_out, data_valid_in = 0;
  logic [4:0] nbr_tag_out;
  logic nbr_last_out, nbr_valid_out, nbr_ready_in = 1, done_out, error_out;
  csr_row_walker #(.DEPTH(DEPTH), .ROWIDX_BASE(RB), .DATA_BASE(DB)) dut (
    .clk_in(clk), .rst_in(rst_in),
    .vertex_in(vertex_in), .tag_in(tag_in), .vertex_valid_in(vertex_valid_in), .vertex_ready_out(vertex_ready_out),
    .rowidx_addr_out(rowidx_addr_out), .rowidx_req_out(rowidx_req_out), .rowidx_in(rowidx_in), .rowidx_valid_in(rowidx_valid_in),
    .data_addr_out(data_addr_out), .data_req_out(data_req_out), .data_in(data_in), .data_valid_in(data_valid_in),
    .nbr_out(nbr_out), .nbr_tag_out(nbr_tag_out), .nbr_last_out(nbr_last_out), .nbr_valid_out(nbr_valid_out),
    .nbr_ready_in(nbr_ready_in), .done_out(done_out), .edge_count_out(edge_count_out), .error_out(error_out)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] dmem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
  endfunction
  logic [31:0] rmem [16];
  function automatic logic [31:0] rrd(input logic [31:0] a);
    logic [31:0] o;
    o = a - RB;
    return o < 16 ? rmem[o[3:0]] : (32'hDEAD0000 ^ a);
  endfunction
  typedef struct { int due; logic [31:0] d; } rsp_t;
  rsp_t dq[$];
  logic [37:0] exp_q[$];
  logic [31:0] exp_cnt_q[$];
  int cyc = 0, lat_min = 1, lat_max = 1, row_due = -1;
  bit hold_rdy = 0, rand_rdy = 0;
  logic [31:0] row_dat;
  int req_cnt = 0, done_cnt = 0, err_cnt = 0, beat_cnt = 0, inflight = 0, fifo_occ = 0, discard = 0, max_occ = 0;
  // memory + downstream model: everything sampled and driven at negedge
  initial forever begin
    rsp_t r;
    int due;
    @(negedge clk);
    cyc++;
    if (rst_in) begin
      exp_q.delete();
      exp_cnt_q.delete();
      discard = inflight;
      fifo_occ = 0;
    end
    rowidx_valid_in = row_due == cyc;
    rowidx_in = rowidx_valid_in ? row_dat : 32'h0;
    data_valid_in = 0;
    data_in = 0;
    if (dq.size() != 0 && dq[0].due == cyc) begin
      r = dq.pop_front();
      data_valid_in = 1;
      data_in = r.d;
      inflight--;
      if (discard > 0) discard--; else fifo_occ++;
    end
    if (rowidx_req_out && !rst_in) begin
      row_due = cyc + $urandom_range(lat_max, lat_min);
      row_dat = rrd(rowidx_addr_out);
    end
    if (data_req_out && !rst_in) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (dq.size() != 0 && dq[dq.size()-1].due >= due) due = dq[dq.size()-1].due + 1;
      r.due = due;
      r.d = dmem(data_addr_out);
      dq.push_back(r);
      inflight++;
      req_cnt++;
    end
    nbr_ready_in = hold_rdy ? 1'b0 : rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
    if (nbr_valid_out && nbr_ready_in && !rst_in) begin
      beat_cnt++;
      fifo_occ--;
      if (exp_q.size() != 0) check("beat", {nbr_last_out, nbr_tag_out, nbr_out}, exp_q.pop_front());
      else check("unexpected_beat_valid", nbr_valid_out, 0);
    end
    if (inflight + fifo_occ > max_occ) max_occ = inflight + fifo_occ;
    if (done_out) begin
      done_cnt++;
      if (exp_cnt_q.size() != 0) check("edge_count", edge_count_out, exp_cnt_q.pop_front());
      else check("unexpected_done", done_out, 0);
    end
    if (error_out) err_cnt++;
  end
  int exp_err = 0;
  task automatic start_walk(input int v, input logic [4:0] t);
    logic [31:0] s, e, c;
    s = rmem[v];
    e = rmem[v+1];
    c = e - s;
    exp_err = 0;
`ifdef CSR_ROW_WALKER_BOUNDS_CHECK_EN
    if (e < s) begin
      c = 0;
      exp_err = 1;
    end
`endif
    for (int k = 0; k < int'(c); k++) exp_q.push_back({k == int'(c) - 1, t, dmem(DB + s + 32'(k))});
    exp_cnt_q.push_back(c);
    @(posedge clk); #2;
    vertex_in = 32'(v);
    tag_in = t;
    vertex_valid_in = 1;
    for (int i = 0; i < 200 && !vertex_ready_out; i++) begin @(posedge clk); #2; end
    check("vertex_ready", vertex_ready_out, 1);
    @(posedge clk); #2;
    vertex_valid_in = 0;
    check("rowidx_req_cycle", rowidx_req_out, 1);
    check("rowidx_addr", rowidx_addr_out, RB + 32'(v));
  endtask
  task automatic finish_walk(input int target, input int e0);
    for (int i = 0; i < 3000 && done_cnt < target; i++) begin @(posedge clk); #2; end
    check("done_seen", done_cnt, target);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin @(posedge clk); #2; end
    check("drained", exp_q.size(), 0);
    check("error_pulses", err_cnt - e0, exp_err);
  endtask
  task automatic walk(input int v, input logic [4:0] t);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    start_walk(v, t);
    finish_walk(d0 + 1, e0);
  endtask
  initial begin
    #900000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int r0, b0, d0, e0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ready", vertex_ready_out, 1);
    check("rst_nbr_valid", nbr_valid_out, 0);
    check("rst_outs", {rowidx_req_out, data_req_out, done_out, error_out, nbr_last_out}, 0);
    check("rst_words", {rowidx_addr_out, edge_count_out}, 0);
    check("rst_nbr", {nbr_out, nbr_tag_out}, 0);
    rst_in = 0;
    rmem[0] = 0; rmem[1] = 3; rmem[2] = 3; rmem[3] = 7;
    for (int i = 4; i < 16; i++) rmem[i] = 7;
    r0 = req_cnt;
    walk(0, 5);
    check("v0_reqs", req_cnt - r0, 3);
    r0 = req_cnt;
    b0 = beat_cnt;
    walk(1, 9);
    check("empty_reqs", req_cnt - r0, 0);
    check("empty_beats", beat_cnt - b0, 0);
    hold_rdy = 1;
    r0 = req_cnt;
    d0 = done_cnt;
    e0 = err_cnt;
    start_walk(2, 17);
    repeat (40) @(posedge clk);
    #2;
    check("stall_reqs", req_cnt - r0, DEPTH);
    check("stall_no_done", done_cnt - d0, 0);
    hold_rdy = 0;
    finish_walk(d0 + 1, e0);
    check("stall_total_reqs", req_cnt - r0, 4);
    lat_min = 1;
    lat_max = 6;
    rand_rdy = 1;
    for (int rnd = 0; rnd < 4; rnd++) begin
      rmem[0] = rnd[0] ? 32'hFFFF_FFF8 : $urandom;
      for (int i = 0; i < 15; i++) rmem[i+1] = rmem[i] + 32'($urandom_range(6));
      for (int w = 0; w < 10; w++) walk($urandom_range(14), 5'($urandom));
    end
    check("occupancy_le_depth", max_occ <= DEPTH, 1);
    rand_rdy = 0;
    lat_min = 6;
    lat_max = 6;
    rmem[0] = 10; rmem[1] = 16; rmem[2] = 18;
    start_walk(0, 3);
    for (int i = 0; i < 100 && inflight < 2; i++) begin @(posedge clk); #2; end
    check("rst_inflight", inflight, 2);
    rst_in = 1;
    @(posedge clk); #2;
    rst_in = 0;
    check("midrst_ready", vertex_ready_out, 1);
    check("midrst_nbr_valid", nbr_valid_out, 0);
    for (int i = 0; i < 100 && (dq.size() != 0 || data_valid_in); i++) begin @(posedge clk); #2; end
    repeat (2) @(posedge clk);
    #2;
    check("late_rsp_nbr_valid", nbr_valid_out, 0);
    check("late_rsp_discarded", discard, 0);
    lat_min = 1;
    lat_max = 3;
    walk(1, 22);
`ifdef CSR_ROW_WALKER_BOUNDS_CHECK_EN
    rmem[0] = 5; rmem[1] = 2;
    r0 = req_cnt;
    walk(0, 1);
    check("bounds_no_reads", req_cnt - r0, 0);
`else
    check("error_never", err_cnt, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/csr_row_walker.md
# csr_row_walker

Request-generation stage directly upstream of `graph_memory`. Accepts a vertex ID plus a 5-bit tag, reads the vertex's two CSR row pointers through the memory's row-index port, then issues one data read per edge index in `[start, end)`. Returned neighbour IDs go into an output FIFO, each tagged and with the final edge marked. Outstanding memory reads are credit-limited, so downstream back-pressure can never overflow the output FIFO.

## Interface
Parameters:
- `DEPTH`, 8: output FIFO entries; this is also the credit pool for outstanding data reads.
- `ROWIDX_BASE`, 32'h0: word address of `rowidx[0]`.
- `DATA_BASE`, 32'h0: word address of `data[0]`.

Ports:
- `clk_in` in 1: single clock.
- `rst_in` in 1: reset, synchronous, active-high.
- `vertex_in` in 32: vertex ID to walk.
- `tag_in` in 5: request tag, carried to every output beat.
- `vertex_valid_in` in 1: request valid.
- `vertex_ready_out` out 1: request accepted when high together with `vertex_valid_in`.
- `rowidx_addr_out` out 32: row-pointer read address.
- `rowidx_req_out` out 1: row-pointer read strobe, one cycle per read.
- `rowidx_in` in 32: row-pointer read data.
- `rowidx_valid_in` in 1: row-pointer data valid.
- `data_addr_out` out 32: edge read address.
- `data_req_out` out 1: edge read strobe.
- `data_in` in 32: edge read data (neighbour ID).
- `data_valid_in` in 1: edge data valid.
- `nbr_out` out 32: neighbour ID.
- `nbr_tag_out` out 5: tag of the walk that produced this neighbour.
- `nbr_last_out` out 1: this is the walk's final neighbour.
- `nbr_valid_out` out 1: FIFO not empty.
- `nbr_ready_in` in 1: downstream dequeues on valid & ready.
- `done_out` out 1: one-cycle pulse when the walk completes.
- `edge_count_out` out 32: `end - start`; valid while `done_out` is high.
- `error_out` out 1: one-cycle pulse on a bounds error (see Configuration).

## Operation
- FSM states: IDLE, REQ_S, WAIT_S, REQ_E, WAIT_E, STREAM, FINISH.
- IDLE: `vertex_ready_out` = 1. On handshake, latch `vertex_in` and `tag_in`, then go to REQ_S.
- REQ_S: pulse `rowidx_req_out` with address `ROWIDX_BASE + v`, then go to WAIT_S.
- WAIT_S: on `rowidx_valid_in`, latch `start` and set `idx = start`, then go to REQ_E.
- REQ_E: pulse `rowidx_req_out` with address `ROWIDX_BASE + v + 1` (32-bit wrap), then go to WAIT_E.
- WAIT_E: on `rowidx_valid_in`, latch `end`.
  - If `start == end`, go to FINISH.
  - Otherwise go to STREAM.
- STREAM issue rule:
  - Each cycle in which `idx != end` and `credits > 0`, assert `data_req_out` with address `DATA_BASE + idx`, increment `idx`, and increment `outstanding`.
  - `credits = DEPTH - fifo_count - outstanding`.
- STREAM response rule:
  - On each `data_valid_in`, enqueue `{last, tag, data_in}` and decrement `outstanding`.
  - Memory responses return in issue order.
  - `last` is set when `idx == end` and `outstanding == 1` (the response being enqueued is the final one).
- STREAM exit: when `idx == end` and `outstanding == 0`, go to FINISH.
- FINISH: pulse `done_out` and `edge_count_out` for one cycle, then go to IDLE. FINISH does not wait for the FIFO to drain.
- An empty row produces no FIFO beat. It produces only `done_out` with `edge_count_out` = 0.
- Same-cycle response, request issue and dequeue: the credit count applies all three updates in that cycle.
- Reset mid-walk: FSM returns to IDLE, FIFO is flushed, `outstanding` is cleared. Responses arriving after reset are ignored.
- Row-pointer strobes arriving outside WAIT_S/WAIT_E are ignored. Data strobes arriving while `outstanding == 0` are ignored.

## Timing
- Reset values: `vertex_ready_out` = 1. All other outputs = 0, with `nbr_valid_out` = 0.
- `rowidx_req_out` asserts the cycle after the request handshake.
- Memory latency is arbitrary, minimum 1 cycle. The walker waits on valid strobes and never counts cycles.
- With a 1-cycle memory and downstream always ready: one data request per cycle. Total walk length = 4 + latency overhead + (`end - start`) cycles.
- `nbr_valid_out` rises the cycle after the first enqueue. The FIFO has no combinational bypass.
- `credits` is never negative. The FIFO never asserts full while a response is in flight.

## Configuration
- `CSR_ROW_WALKER_BOUNDS_CHECK_EN` defined:
  - In WAIT_E, if `end < start` (unsigned), pulse `error_out`, then go to FINISH.
  - `edge_count_out` = 0 and no data reads are issued.
- Undefined:
  - No comparator; `error_out` is tied to 0.
  - The walker issues reads from `idx = start` until `idx == end` with 32-bit wrap-around.

## Structure
- Shared package `graph_pkg` holds:
  - `walker_state_t` (FSM enum).
  - `nbr_beat_t` (packed struct `{last, tag[4:0], id[31:0]}`, 38 bits).
  - `TAG_W = 5`.
- Sub-module: the existing `FIFO`, with `DATA_WIDTH = $bits(nbr_beat_t)` and `DEPTH = DEPTH`. The FIFO exposes an occupancy count, or the walker keeps a shadow counter.

## Test plan
- rowidx = [0, 3, 3, 7]. Walk v=0, tag=5 → nbrs `data[0..2]` with tag 5, `last` on the third beat, `done_out` with count 3.
- Walk v=1 (empty row, 3→3) → no FIFO beats, `done_out` with `edge_count_out` = 0.
- Walk v=2 (4 edges), `DEPTH` = 2, `nbr_ready_in` held low → exactly 2 `data_req_out` pulses, then stall. Release ready → remaining 2 issued, all 4 delivered in order.
- Random memory latency 1–6 cycles on both ports → output order and tags match the golden model. `outstanding` never exceeds `DEPTH`.
- Assert `rst_in` during STREAM with 2 reads outstanding → next cycle `vertex_ready_out` = 1 and `nbr_valid_out` = 0. Late `data_valid_in` pulses enqueue nothing.
- With the macro defined, rowidx = [5, 2] and walk v=0 → `error_out` pulse, zero data reads, `done_out` with count 0.
